// File: rtl/dcache_ctrl.sv
// Direct-mapped write-back/write-allocate D-cache controller between the MEM stage and a line-wide main memory.
// Latency: hits in 1 cycle; a clean miss costs 1 + N + 1 cycles, and a dirty miss adds the victim writeback wait.
// Backpressure: o_cpu_stall holds the pipeline off during misses and flushes; memory requests are held until i_mem_rdy.
module dcache_ctrl #(
    parameter int INDEX_BITS = 3
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [15:0] i_cpu_addr,
    input  logic        i_cpu_rd,
    input  logic        i_cpu_wr,
    input  logic [15:0] i_cpu_wdata,
    output logic [15:0] o_cpu_rdata,
    output logic        o_cpu_stall,
    input  logic        i_flush,
    output logic        o_flush_done,
    output logic [13:0] o_mem_addr,
    output logic        o_mem_rd,
    output logic        o_mem_wr,
    output logic [63:0] o_mem_wdata,
    input  logic [63:0] i_mem_rdata,
    input  logic        i_mem_rdy
);

    localparam int LINES    = 2 ** INDEX_BITS;
    localparam int TAG_BITS = 14 - INDEX_BITS;
    localparam logic [INDEX_BITS:0] LAST_LINE = (INDEX_BITS + 1)'(LINES - 1);
    localparam logic [INDEX_BITS:0] CNT_ONE   = (INDEX_BITS + 1)'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITEBACK,
        S_ALLOCATE,
        S_FLUSH_SCAN,
        S_FLUSH_WB,
        S_FLUSH_DONE
    } state_t;

    state_t              r_state;
    logic [LINES-1:0]    r_valid;
    logic [LINES-1:0]    r_dirty;
    logic [TAG_BITS-1:0] r_tag  [LINES];
    logic [63:0]         r_data [LINES];
    logic [INDEX_BITS:0] r_cnt;

    logic [13:0]         r_mem_addr;
    logic                r_mem_rd;
    logic                r_mem_wr;
    logic [63:0]         r_mem_wdata;
    logic                r_flush_done;

    // Address decode of the CPU request.
    logic [1:0]            w_off;
    logic [INDEX_BITS-1:0] w_idx;
    logic [TAG_BITS-1:0]   w_tag;
    logic [INDEX_BITS-1:0] w_fidx;
    logic [63:0]           w_line;
    logic                  w_req;
    logic                  w_hit;
    logic                  w_wr_hit;
    logic                  w_fill;
    logic                  w_last;

    assign w_off  = i_cpu_addr[1:0];
    assign w_idx  = i_cpu_addr[INDEX_BITS+1:2];
    assign w_tag  = i_cpu_addr[15:INDEX_BITS+2];
    assign w_fidx = r_cnt[INDEX_BITS-1:0];
    assign w_line = r_data[w_idx];
    assign w_last = (r_cnt == LAST_LINE);

    assign w_req    = i_cpu_rd | i_cpu_wr;
    assign w_hit    = w_req & r_valid[w_idx] & (r_tag[w_idx] == w_tag);
    // A pending flush wins over a hit, so the write must not land in that cycle.
    assign w_wr_hit = (r_state == S_IDLE) & ~i_flush & i_cpu_wr & w_hit;
    assign w_fill   = (r_state == S_ALLOCATE) & i_mem_rdy;

    assign o_cpu_rdata  = w_line[{w_off, 4'b0000} +: 16];
    assign o_cpu_stall  = (r_state != S_IDLE) | i_flush | (w_req & ~w_hit);

    assign o_mem_addr   = r_mem_addr;
    assign o_mem_rd     = r_mem_rd;
    assign o_mem_wr     = r_mem_wr;
    assign o_mem_wdata  = r_mem_wdata;
    assign o_flush_done = r_flush_done;

    // Tag and data arrays: line fills and write-hit word merges; left unreset on purpose.
    always_ff @(posedge i_clk) begin
        if (w_fill) begin
            r_data[w_idx] <= i_mem_rdata;
            r_tag[w_idx]  <= w_tag;
        end else if (w_wr_hit) begin
            r_data[w_idx][{w_off, 4'b0000} +: 16] <= i_cpu_wdata;
        end
    end

    // Controller FSM: valid/dirty bookkeeping, flush walk and registered memory handshake.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state      <= S_IDLE;
            r_valid      <= '0;
            r_dirty      <= '0;
            r_cnt        <= '0;
            r_mem_addr   <= '0;
            r_mem_rd     <= 1'b0;
            r_mem_wr     <= 1'b0;
            r_mem_wdata  <= '0;
            r_flush_done <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_flush) begin
                        r_cnt   <= '0;
                        r_state <= S_FLUSH_SCAN;
                    end else if (w_req & ~w_hit) begin
                        if (r_valid[w_idx] & r_dirty[w_idx]) begin
                            r_mem_wr    <= 1'b1;
                            r_mem_addr  <= {r_tag[w_idx], w_idx};
                            r_mem_wdata <= r_data[w_idx];
                            r_state     <= S_WRITEBACK;
                        end else begin
                            r_mem_rd    <= 1'b1;
                            r_mem_addr  <= i_cpu_addr[15:2];
                            r_state     <= S_ALLOCATE;
                        end
                    end else if (w_wr_hit) begin
                        r_dirty[w_idx] <= 1'b1;
                    end
                end
                S_WRITEBACK: begin
                    if (i_mem_rdy) begin
                        r_dirty[w_idx] <= 1'b0;
                        r_mem_wr       <= 1'b0;
                        r_mem_rd       <= 1'b1;
                        r_mem_addr     <= i_cpu_addr[15:2];
                        r_state        <= S_ALLOCATE;
                    end
                end
                S_ALLOCATE: begin
                    // The request is re-evaluated as a hit in IDLE, where a pending write merges.
                    if (i_mem_rdy) begin
                        r_valid[w_idx] <= 1'b1;
                        r_dirty[w_idx] <= 1'b0;
                        r_mem_rd       <= 1'b0;
                        r_state        <= S_IDLE;
                    end
                end
                S_FLUSH_SCAN: begin
                    if (r_valid[w_fidx] & r_dirty[w_fidx]) begin
                        r_mem_wr    <= 1'b1;
                        r_mem_addr  <= {r_tag[w_fidx], w_fidx};
                        r_mem_wdata <= r_data[w_fidx];
                        r_state     <= S_FLUSH_WB;
                    end else begin
                        r_cnt <= r_cnt + CNT_ONE;
                        if (w_last) begin
                            r_flush_done <= 1'b1;
                            r_state      <= S_FLUSH_DONE;
                        end
                    end
                end
                S_FLUSH_WB: begin
                    if (i_mem_rdy) begin
                        r_dirty[w_fidx] <= 1'b0;
                        r_mem_wr        <= 1'b0;
                        r_cnt           <= r_cnt + CNT_ONE;
                        if (w_last) begin
                            r_flush_done <= 1'b1;
                            r_state      <= S_FLUSH_DONE;
                        end else begin
                            r_state      <= S_FLUSH_SCAN;
                        end
                    end
                end
                S_FLUSH_DONE: begin
                    r_flush_done <= 1'b0;
                    r_state      <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
